hci_bank_stall_arbiter: RTL
===========================

// Module: hci_bank_stall_arbiter
// PURPOSE
//  Shares one TCDM bank port between two requester branches: A (log-interconnect side) and B (HWPE/shallow side).
//  Fixed priority, with a starvation counter that forces one grant to the low-priority branch after a programmable stall count.
//  Steers the 1-cycle-latency bank response back to the branch that was granted. One instance sits per bank, in front of hci_mem_intf.
// PARAMETERS
//  AW  32  address width, passed through unchanged
//  DW  32  data width (including user bits)
//  BW   8  bits per byte-enable lane; byte enable is DW/BW bits wide
//  SW   8  stall-counter width; must satisfy SW >= 1
// PORTS
//  clk_i                 in   1       clock
//  rst_ni                in   1       synchronous reset, active low
//  invert_prio_i         in   1       0: A is high priority; 1: B is high priority
//  low_prio_max_stall_i  in   SW      stall threshold; 0 = strict priority, no forcing
//  a_req_i/b_req_i       in   1       branch request
//  a_add_i/b_add_i       in   AW      branch address
//  a_wen_i/b_wen_i       in   1       1 = read, 0 = write
//  a_data_i/b_data_i     in   DW      write data
//  a_be_i/b_be_i         in   DW/BW   byte enables
//  a_gnt_o/b_gnt_o       out  1       branch grant
//  a_r_valid_o/b_r_valid_o out 1      response valid (reads and writes)
//  a_r_data_o/b_r_data_o out  DW      response data
//  mem_req_o             out  1       bank request
//  mem_add_o/mem_wen_o/mem_data_o/mem_be_o out  AW/1/DW/DW/BW  bank request fields
//  mem_gnt_i             in   1       bank grant
//  mem_r_data_i          in   DW      bank read data, valid 1 cycle after grant
//  stall_cnt_o           out  SW      current stall count, for debug
// BEHAVIOUR
//  - Selection is combinational.
//    hi = invert_prio_i ? B : A; lo = the other branch.
//    force = (max!=0) && (stall_q >= max).
//    The winner is lo if lo_req && (force || !hi_req); otherwise it is hi if hi_req; otherwise there is no winner.
//  - mem_req_o = a_req_i | b_req_i. mem_add/wen/data/be = winner's fields; A's fields are driven when there is no winner.
//  - x_gnt_o = (winner==x) & mem_gnt_i. The loser's gnt is always 0. Requesters hold their request until granted.
//  - Stall counter stall_q, updated at the clock edge:
//    - Clear to 0 when lo is granted, or when lo_req = 0.
//    - Increment (saturating at 2^SW-1) when lo_req & hi_req & hi granted.
//    - Otherwise hold. This includes the case mem_gnt_i = 0.
//  - Forcing is one-shot. The lo grant clears stall_q, so hi regains priority on the next cycle.
//  - With max = 1 the branches alternate while both request.
//  - max is compared with >=. Lowering max below stall_q forces a lo grant on the next contended cycle.
//  - Toggling invert_prio_i: the hi/lo roles swap immediately. stall_q is cleared on any cycle where invert_prio_i differs from its registered copy.
//  - Response path: a registered r_sel_q is loaded with {valid = mem_req_o & mem_gnt_i, branch = winner}.
//    - x_r_valid_o = r_sel_q.valid & (r_sel_q.branch == x).
//    - Both x_r_data_o = mem_r_data_i, unmasked; consumers must qualify with r_valid.
//    - Latency is exactly 1 cycle from grant to r_valid. Back-to-back grants yield back-to-back responses.
//  - Reset (rst_ni = 0 at a clock edge): stall_q = 0, r_sel_q.valid = 0, invert_prio register = 0.
//    Outputs after reset: r_valid = 0, stall_cnt_o = 0. gnt follows the inputs combinationally.
//    An outstanding response in flight when reset is asserted is dropped; no r_valid is produced for it.
//  - The block makes no assumption about the address; it does not decode bank bits.
// TESTING
//  1. Reset: rst_ni = 0 for 2 cycles with both reqs high, mem_gnt_i = 0 -> a/b_r_valid_o = 0, stall_cnt_o = 0.
//  2. Strict priority: max = 0, invert = 0, both request continuously, mem_gnt_i = 1 for 300 cycles
//     -> a_gnt_o = 1 every cycle; b_gnt_o never asserts; stall_cnt_o saturates at 255.
//  3. Starvation forcing: max = 3, both request continuously, mem_gnt_i = 1
//     -> grant pattern A,A,A,B repeating; stall_cnt_o sequence 0,1,2,3,0.
//  4. Bank backpressure: max = 2, both request, mem_gnt_i low for 5 cycles mid-sequence
//     -> stall_cnt_o holds its value; no gnt is asserted; the pattern resumes afterwards.
//  5. Response routing: A reads at cycle t with mem_r_data_i = 0xCAFE0001 at t+1; B writes at t+1
//     -> a_r_valid_o at t+1 with data 0xCAFE0001; b_r_valid_o at t+2 only.
//  6. Priority inversion: invert = 1, max = 0, both request -> only b_gnt_o asserts.
//     Toggling invert mid-run -> stall_cnt_o reads 0 on the following cycle.

Source files
------------

// File: rtl/hci_bank_stall_arbiter_if.sv
// Bundle of the two requester branches and the bank port around one
// hci_bank_stall_arbiter; the arbiter connects through the slave modport.
interface hci_bank_stall_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 8
) ();
    localparam int unsigned BEW = DW / BW;

    logic           a_req;
    logic [AW-1:0]  a_add;
    logic           a_wen;
    logic [DW-1:0]  a_data;
    logic [BEW-1:0] a_be;
    logic           a_gnt;
    logic           a_r_valid;
    logic [DW-1:0]  a_r_data;

    logic           b_req;
    logic [AW-1:0]  b_add;
    logic           b_wen;
    logic [DW-1:0]  b_data;
    logic [BEW-1:0] b_be;
    logic           b_gnt;
    logic           b_r_valid;
    logic [DW-1:0]  b_r_data;

    logic           mem_req;
    logic [AW-1:0]  mem_add;
    logic           mem_wen;
    logic [DW-1:0]  mem_data;
    logic [BEW-1:0] mem_be;
    logic           mem_gnt;
    logic [DW-1:0]  mem_r_data;

    modport slave (
        input  a_req, a_add, a_wen, a_data, a_be,
        output a_gnt, a_r_valid, a_r_data,
        input  b_req, b_add, b_wen, b_data, b_be,
        output b_gnt, b_r_valid, b_r_data,
        output mem_req, mem_add, mem_wen, mem_data, mem_be,
        input  mem_gnt, mem_r_data
    );

    modport master (
        output a_req, a_add, a_wen, a_data, a_be,
        input  a_gnt, a_r_valid, a_r_data,
        output b_req, b_add, b_wen, b_data, b_be,
        input  b_gnt, b_r_valid, b_r_data,
        input  mem_req, mem_add, mem_wen, mem_data, mem_be,
        output mem_gnt, mem_r_data
    );
endinterface

// File: rtl/hci_bank_stall_arbiter.sv
// Two-branch TCDM bank arbiter: fixed priority with one-shot starvation forcing
// of the low-priority branch, and 1-cycle response steering to the granted branch.
module hci_bank_stall_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned SW = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       invert_prio_i,
    input  logic [SW-1:0]              low_prio_max_stall_i,
    output logic [SW-1:0]              stall_cnt_o,
    hci_bank_stall_arbiter_if.slave    bus
);
    localparam int unsigned BEW = DW / BW;

    typedef enum logic { BR_A = 1'b0, BR_B = 1'b1 } branch_e;

    typedef struct packed {
        logic    valid;
        branch_e branch;
    } r_sel_t;

    logic [SW-1:0]  stall_q, stall_d;
    logic           invert_q;
    r_sel_t         r_sel_q, r_sel_d;

    logic           hi_req, lo_req, force_lo;
    logic           win_lo, win_hi, win_any;
    branch_e        winner;
    logic           lo_granted, hi_granted;

    logic [AW-1:0]  sel_add;
    logic           sel_wen;
    logic [DW-1:0]  sel_data;
    logic [BEW-1:0] sel_be;

    always_comb begin
        hi_req   = invert_prio_i ? bus.b_req : bus.a_req;
        lo_req   = invert_prio_i ? bus.a_req : bus.b_req;
        force_lo = (low_prio_max_stall_i != '0) && (stall_q >= low_prio_max_stall_i);
        win_lo   = lo_req && (force_lo || !hi_req);
        win_hi   = !win_lo && hi_req;
        win_any  = win_lo || win_hi;
        // Branch B wins when it holds the winning role (hi if inverted, lo otherwise).
        winner   = ((invert_prio_i && win_hi) || (!invert_prio_i && win_lo)) ? BR_B : BR_A;
        lo_granted = win_lo && bus.mem_gnt;
        hi_granted = win_hi && bus.mem_gnt;
    end

    always_comb begin
        sel_add  = bus.a_add;
        sel_wen  = bus.a_wen;
        sel_data = bus.a_data;
        sel_be   = bus.a_be;
        if (winner == BR_B) begin
            sel_add  = bus.b_add;
            sel_wen  = bus.b_wen;
            sel_data = bus.b_data;
            sel_be   = bus.b_be;
        end
    end

    assign bus.mem_req  = bus.a_req | bus.b_req;
    assign bus.mem_add  = sel_add;
    assign bus.mem_wen  = sel_wen;
    assign bus.mem_data = sel_data;
    assign bus.mem_be   = sel_be;

    assign bus.a_gnt = win_any && (winner == BR_A) && bus.mem_gnt;
    assign bus.b_gnt = win_any && (winner == BR_B) && bus.mem_gnt;

    always_comb begin
        stall_d = stall_q;
        if (invert_prio_i != invert_q || lo_granted || !lo_req) begin
            stall_d = '0;
        end else if (hi_req && hi_granted) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + 1'b1;
        end
        r_sel_d.valid  = bus.mem_req && bus.mem_gnt;
        r_sel_d.branch = winner;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_q  <= '0;
            invert_q <= 1'b0;
            r_sel_q  <= '{valid: 1'b0, branch: BR_A};
        end else begin
            stall_q  <= stall_d;
            invert_q <= invert_prio_i;
            r_sel_q  <= r_sel_d;
        end
    end

    assign stall_cnt_o   = stall_q;
    assign bus.a_r_valid = r_sel_q.valid && (r_sel_q.branch == BR_A);
    assign bus.b_r_valid = r_sel_q.valid && (r_sel_q.branch == BR_B);
    assign bus.a_r_data  = bus.mem_r_data;
    assign bus.b_r_data  = bus.mem_r_data;

endmodule
